// File: rtl/fsm_seq_step_timer_if.sv
// Signal bundle between the step timer and its sequencer/config master.
// lap and lap_clr exist only when FSM_SEQ_STEP_TIMER_LAP_EN is defined.
interface fsm_seq_step_timer_if #(
    parameter int CNT_W = 8
`ifdef FSM_SEQ_STEP_TIMER_LAP_EN
    , parameter int LAP_W = 16
`endif
);
    logic             en;
    logic             hold;
    logic             adv;
    logic [2:0]       st;
    logic             cfg_we;
    logic [2:0]       cfg_addr;
    logic [CNT_W-1:0] cfg_data;
    logic [7:0]       t;
    logic [CNT_W-1:0] cnt;
`ifdef FSM_SEQ_STEP_TIMER_LAP_EN
    logic [LAP_W-1:0] lap;
    logic             lap_clr;
`endif

    modport master (
        output en, hold, adv, st, cfg_we, cfg_addr, cfg_data,
`ifdef FSM_SEQ_STEP_TIMER_LAP_EN
        output lap_clr,
        input  lap,
`endif
        input  t, cnt
    );

    modport slave (
        input  en, hold, adv, st, cfg_we, cfg_addr, cfg_data,
`ifdef FSM_SEQ_STEP_TIMER_LAP_EN
        input  lap_clr,
        output lap,
`endif
        output t, cnt
    );
endinterface

// File: rtl/fsm_seq_step_timer.sv
// Per-state dwell timer issuing one-cycle transition strobes to the 8-state sequencer.
// Optional lap counter enabled by FSM_SEQ_STEP_TIMER_LAP_EN.
module fsm_seq_step_timer #(
    parameter int CNT_W = 8
`ifdef FSM_SEQ_STEP_TIMER_LAP_EN
    , parameter int LAP_W = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    fsm_seq_step_timer_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, COUNT, FIRE, WAIT} state_t;

    state_t           state, nxt;
    logic [CNT_W-1:0] dwell [8];
    logic [2:0]       st_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       t_q, t_d;
    logic [CNT_W-1:0] base;
    logic             chg;
    logic             live;

    assign chg = (bus.st != st_q);

    // The cycle in which a new st is first seen is dwell cycle 0 of that
    // state, so a WAIT that observes the change already makes the compare.
    always_comb begin
        nxt   = state;
        cnt_d = cnt_q;
        t_d   = '0;
        live  = 1'b0;
        base  = cnt_q;
        case (state)
            IDLE: begin
                cnt_d = '0;
                if (bus.en) nxt = COUNT;
            end
            COUNT: live = 1'b1;
            FIRE: begin
                cnt_d = '0;
                nxt   = WAIT;
            end
            WAIT: begin
                cnt_d = '0;
                live  = chg;
            end
            default: nxt = IDLE;
        endcase

        if (live) begin
            if (chg) base = '0;
            // >= keeps a dwell rewritten below the running count from stalling
            if (bus.adv || (!bus.hold && base >= dwell[bus.st])) begin
                nxt   = FIRE;
                cnt_d = '0;
                t_d   = 8'b1 << bus.st;
            end else begin
                nxt   = COUNT;
                cnt_d = (bus.hold || (&base)) ? base : base + CNT_W'(1);
            end
        end

        // A strobe already registered always completes.
        if (!bus.en && state != FIRE) begin
            nxt   = IDLE;
            cnt_d = '0;
            t_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            st_q  <= '0;
            cnt_q <= '0;
            t_q   <= '0;
            for (int i = 0; i < 8; i++) dwell[i] <= '1;
        end else begin
            state <= nxt;
            st_q  <= bus.st;
            cnt_q <= cnt_d;
            t_q   <= t_d;
            if (bus.cfg_we) dwell[bus.cfg_addr] <= bus.cfg_data;
        end
    end

    assign bus.t   = t_q;
    assign bus.cnt = cnt_q;

`ifdef FSM_SEQ_STEP_TIMER_LAP_EN
    logic [LAP_W-1:0] lap_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              lap_q <= '0;
        else if (bus.lap_clr) lap_q <= '0;
        else if (t_q[7])      lap_q <= lap_q + LAP_W'(1);
    end

    assign bus.lap = lap_q;
`endif
endmodule

// File: tb/tb_fsm_seq_step_timer.sv
// Bench for fsm_seq_step_timer: directed plan steps plus randomized traffic against a cycle model.
module tb_fsm_seq_step_timer;
    localparam int CNT_W = 8;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fsm_seq_step_timer_if #(.CNT_W(CNT_W)) bus ();
    fsm_seq_step_timer #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    // Sequencer model: advances on its own strobe unless stuck.
    logic [2:0] seq_st;
    logic       stuck = 1'b0;
    always @(posedge clk or posedge rst) begin
        if (rst)                          seq_st <= 3'd0;
        else if (!stuck && bus.t[seq_st]) seq_st <= seq_st + 3'd1;
    end
    assign bus.st = seq_st;

    int checks = 0;
    int errors = 0;

    // Behavioural expectation of the block
    logic [7:0] m_t;
    int         m_cnt;
    bit         m_on, m_wait;
    logic [2:0] m_prev;
    int         m_dw [8];
`ifdef FSM_SEQ_STEP_TIMER_LAP_EN
    logic [15:0] m_lap;
`endif

    int         cyc = 0, enter = 0, n_chg = 0;
    int         occ [8];
    logic [2:0] last_st = 3'd0;
    logic [7:0] strobes [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_t = '0; m_cnt = 0; m_on = 0; m_wait = 0; m_prev = '0;
        for (int i = 0; i < 8; i++) m_dw[i] = MAXC;
`ifdef FSM_SEQ_STEP_TIMER_LAP_EN
        m_lap = '0;
`endif
    endtask

    // Predicts outputs after the coming edge from the inputs now applied.
    task automatic model_step();
        logic [7:0] nt;
        int         ncnt, el;
        logic [2:0] s;
        s = bus.st; nt = '0; ncnt = 0;
        if (m_t != 0) m_wait = 1;
        else if (!bus.en) begin m_on = 0; m_wait = 0; end
        else if (!m_on) begin m_on = 1; m_wait = 0; end
        else if (!(m_wait && s == m_prev)) begin
            el = (s != m_prev) ? 0 : m_cnt;
            m_wait = 0;
            if (bus.adv || (!bus.hold && el >= m_dw[s])) nt = 8'd1 << s;
            else ncnt = bus.hold ? el : ((el < MAXC) ? el + 1 : MAXC);
        end
`ifdef FSM_SEQ_STEP_TIMER_LAP_EN
        if (bus.lap_clr) m_lap = '0;
        else if (m_t[7]) m_lap = m_lap + 16'd1;
`endif
        if (bus.cfg_we) m_dw[bus.cfg_addr] = int'(bus.cfg_data);
        m_prev = s; m_t = nt; m_cnt = ncnt;
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        cyc++;
        if (bus.st != last_st) begin
            occ[last_st] = cyc - enter;
            enter = cyc; last_st = bus.st; n_chg++;
        end
        if (bus.t != 0) strobes.push_back(bus.t);
        chk("t", bus.t, m_t);
        chk("cnt", bus.cnt, m_cnt);
        chk("onehot", ($countones(bus.t) <= 1), 1);
`ifdef FSM_SEQ_STEP_TIMER_LAP_EN
        chk("lap", bus.lap, m_lap);
`endif
    endtask

    task automatic wr(input int a, input int d);
        bus.cfg_we = 1'b1; bus.cfg_addr = 3'(a); bus.cfg_data = CNT_W'(d);
        tick();
        bus.cfg_we = 1'b0;
    endtask

    task automatic wait_st_cnt(input int s, input int c, input int budget, input string tag);
        int n = 0;
        while (!(bus.st == 3'(s) && bus.cnt == CNT_W'(c)) && n < budget) begin tick(); n++; end
        chk(tag, (n < budget), 1);
    endtask

    initial begin
        bus.en = 0; bus.hold = 0; bus.adv = 0;
        bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_data = '0;
`ifdef FSM_SEQ_STEP_TIMER_LAP_EN
        bus.lap_clr = 0;
`endif
        model_reset();
        for (int i = 0; i < 8; i++) occ[i] = 0;
        repeat (2) @(negedge clk);
        chk("rst_t", bus.t, 0);
        chk("rst_cnt", bus.cnt, 0);
`ifdef FSM_SEQ_STEP_TIMER_LAP_EN
        chk("rst_lap", bus.lap, 0);
`endif
        rst = 1'b0;
        last_st = bus.st; enter = cyc;

        // dwell 3 everywhere: occupancy 5, strobes walk 0x01..0x80
        for (int i = 0; i < 8; i++) wr(i, 3);
        bus.en = 1; strobes.delete();
        begin
            int n = 0;
            while (strobes.size() < 9 && n < 200) begin tick(); n++; end
            chk("t1_done", (strobes.size() >= 9), 1);
        end
        tick();
        for (int k = 0; k < 9 && k < strobes.size(); k++)
            chk($sformatf("t1_seq%0d", k), strobes[k], 8'd1 << (k % 8));
        for (int i = 0; i < 8; i++) chk($sformatf("t1_occ%0d", i), occ[i], 3 + 2);

        // dwell[2]=0, others 1
        for (int i = 0; i < 8; i++) wr(i, (i == 2) ? 0 : 1);
        begin
            int n = 0, c0;
            while (!(bus.st == 3'd0 && enter == cyc) && n < 100) begin tick(); n++; end
            chk("t2_sync", (n < 100), 1);
            c0 = n_chg; n = 0;
            while (n_chg - c0 < 8 && n < 100) begin tick(); n++; end
            chk("t2_lap", (n < 100), 1);
            for (int i = 0; i < 8; i++) chk($sformatf("t2_occ%0d", i), occ[i], ((i == 2) ? 0 : 1) + 2);
        end

        // hold in state 4 at cnt 2 with dwell 5
        wr(4, 5);
        wait_st_cnt(4, 2, 100, "t3_reach");
        bus.hold = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t3_hold_cnt", bus.cnt, 2);
            chk("t3_hold_t", bus.t, 0);
        end
        bus.hold = 0;
        begin
            int n = 0;
            while (bus.t == 0 && n < 20) begin tick(); n++; end
            chk("t3_lat", n, 4);
            chk("t3_t", bus.t, 8'h10);
        end

        // forced advance in state 1, sequencer stuck afterwards
        wr(1, 200);
        wait_st_cnt(1, 0, 100, "t4_reach");
        bus.adv = 1; stuck = 1;
        tick();
        bus.adv = 0;
        chk("t4_adv_t", bus.t, 8'h02);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t4_nofire", bus.t, 0);
            chk("t4_st", bus.st, 1);
        end
        bus.en = 0; tick();
        wr(1, 1);
        bus.en = 1; stuck = 0; tick();

        // dwell lowered below running count in state 6, then disable during FIRE
        wr(6, 200);
        wait_st_cnt(6, 50, 400, "t5_reach");
        bus.cfg_we = 1; bus.cfg_addr = 3'd6; bus.cfg_data = CNT_W'(10);
        tick();
        bus.cfg_we = 0;
        chk("t5_oldcmp", bus.t, 0);
        tick();
        chk("t5_fire", bus.t, 8'h40);
        bus.en = 0;
        tick();
        chk("t5_done_t", bus.t, 0);
        chk("t5_done_cnt", bus.cnt, 0);
        tick();
        chk("t5_idle_cnt", bus.cnt, 0);
        chk("t5_st", bus.st, 7);
        for (int i = 0; i < 4; i++) begin tick(); chk("t5_idle_t", bus.t, 0); end
        bus.en = 1;
        wr(6, 1);

`ifdef FSM_SEQ_STEP_TIMER_LAP_EN
        for (int i = 0; i < 8; i++) wr(i, 0);
        bus.lap_clr = 1; tick(); bus.lap_clr = 0;
        begin
            int n = 0, nl;
            nl = bus.t[7] ? 1 : 0;
            while (nl < 3 && n < 300) begin tick(); n++; if (bus.t[7]) nl++; end
            chk("lap_run", (n < 300), 1);
            tick();
            chk("lap3", bus.lap, 3);
            n = 0;
            while (bus.t != 8'h80 && n < 40) begin tick(); n++; end
            chk("lap_t7", bus.t, 8'h80);
            bus.lap_clr = 1; tick(); bus.lap_clr = 0;
            chk("lap_clr", bus.lap, 0);
        end
`endif

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            bus.en       = ($urandom_range(0, 99) >= 3);
            bus.hold     = ($urandom_range(0, 99) < 20);
            bus.adv      = ($urandom_range(0, 99) < 8);
            bus.cfg_we   = ($urandom_range(0, 99) < 10);
            bus.cfg_addr = 3'($urandom_range(0, 7));
            bus.cfg_data = CNT_W'($urandom_range(0, 6));
`ifdef FSM_SEQ_STEP_TIMER_LAP_EN
            bus.lap_clr  = ($urandom_range(0, 99) < 2);
`endif
            tick();
        end
        bus.hold = 0; bus.adv = 0; bus.cfg_we = 0; bus.en = 1;
`ifdef FSM_SEQ_STEP_TIMER_LAP_EN
        bus.lap_clr = 0;
`endif
        repeat (5) tick();

        // asynchronous reset mid-run; dwell back to all-ones
        #2 rst = 1'b1;
        #1;
        chk("arst_t", bus.t, 0);
        chk("arst_cnt", bus.cnt, 0);
`ifdef FSM_SEQ_STEP_TIMER_LAP_EN
        chk("arst_lap", bus.lap, 0);
`endif
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        last_st = bus.st; enter = cyc;
        begin
            int n = 0;
            while (bus.t == 0 && n < 300) begin tick(); n++; end
            chk("arst_dwell_lat", n, MAXC + 2);
            chk("arst_dwell_t", bus.t, 8'h01);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fsm_seq_step_timer.md
# fsm_seq_step_timer

Timed transition-request generator for the 8-state sequential-encoded sequencer. Samples the sequencer state `st`, counts per-state dwell cycles against programmable limits, and issues one-cycle transition strobes `t[i]`, meaning "move from state i to state i+1 mod 8". It sits directly upstream of the sequencer: `t[0]..t[7]` drive t01..t70, and the sequencer's `st` feeds back into this block.

## Interface
- `CNT_W`, 8: dwell counter and dwell register width.
- `LAP_W`, 16: lap counter width; used only with `FSM_SEQ_STEP_TIMER_LAP_EN`.

- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `en` in 1: enable; 0 forces IDLE.
- `hold` in 1: freezes dwell counting.
- `adv` in 1: forced advance request, level-sampled.
- `st` in 3: current sequencer state, fed back from the sequencer.
- `cfg_we` in 1: dwell register write strobe.
- `cfg_addr` in 3: dwell register index, which is the state number.
- `cfg_data` in CNT_W: dwell value.
- `t` out 8: registered one-hot transition strobes.
- `cnt` out CNT_W: current dwell count.
- `lap` out LAP_W: completed laps; present only with the macro.
- `lap_clr` in 1: synchronous lap clear; present only with the macro.

## Operation
- Dwell registers `dwell[0..7]`:
  - Reset to all-ones.
  - Written at the clock edge when `cfg_we=1`.
  - Writes are legal at any time and take effect on the next compare.
- `st_q` registers `st` every cycle. Reset value is 0, matching sequencer S0.
- FSM states: IDLE, COUNT, FIRE, WAIT. Reset state is IDLE.
- IDLE:
  - `cnt=0`, `t=0`.
  - Moves to COUNT when `en=1`.
- COUNT:
  - If `st!=st_q`, `cnt` clears to 0.
  - Else if `hold=0`, `cnt` increments, saturating at all-ones.
  - Moves to FIRE when `adv=1` (adv overrides hold), or when `hold=0` and `cnt>=dwell[st]`.
  - Uses `>=` so that a dwell rewritten below the current count cannot hang the block.
- FIRE:
  - `t[st_q]=1` for exactly one cycle, where `st_q` is the state captured at the fire decision.
  - Always moves to WAIT.
  - `hold`, `adv` and `en` do not cancel a strobe in progress.
- WAIT:
  - `t=0`.
  - When `st!=st_q`, clears `cnt` and moves to COUNT.
  - If `st` never changes, the block stays in WAIT. No re-fire and no timeout.
- `en=0` in COUNT, FIRE or WAIT:
  - From COUNT or WAIT, moves to IDLE next cycle.
  - From FIRE, completes the strobe first, then moves to IDLE.
  - Re-enabling restarts counting from 0 in the current `st`.
- `t` is never multi-hot. It is asserted only from FIRE.
- Reset mid-operation: all outputs clear asynchronously and `dwell` returns to all-ones.

## Timing
- Dwell D, state s first observed in cycle 0, no hold or adv:
  - `cnt==D` in cycle D.
  - `t[s]=1` in cycle D+1.
  - `st` shows s+1 in cycle D+2.
  - State occupancy is therefore D+2 cycles; D=0 gives 2 cycles.
- `adv` sampled high in COUNT in cycle k gives `t` in cycle k+1.
- There is a minimum of 2 cycles between consecutive strobes.
- Reset values:
  - `t=0`, `cnt=0`, `lap=0`.
  - FSM in IDLE, `st_q=0`.
- `cfg_we` and a compare in the same cycle: the compare uses the old dwell value.

## Configuration
- `FSM_SEQ_STEP_TIMER_LAP_EN` defined:
  - Adds the `lap` output and the `lap_clr` input.
  - `lap` increments, wrapping, on each cycle in which `t[7]=1`.
  - `lap_clr` has priority over a simultaneous increment.
- Not defined: the ports and the counter are absent, and the remaining behaviour is identical.

## Test plan
- Reset, write `dwell[0..7]=3`, `en=1`, bench sequencer model connected -> each state is occupied 5 cycles, and `t` shows `0x01, 0x02, …, 0x80` in order.
- `dwell[2]=0`, others 1 -> state 2 lasts 2 cycles and other states last 3; never more than one `t` bit high.
- In state 4, `hold=1` for 10 cycles at `cnt=2` with `dwell[4]=5` -> `cnt` stays 2 and there is no strobe; releasing hold gives `t[4]` 4 cycles later.
- Pulse `adv` in state 1 with `cnt=0`, `dwell[1]=200` -> `t=0x02` next cycle; hold the sequencer model stuck in state 1 -> block stays in WAIT with no second strobe.
- In state 6 at `cnt=50`, write `dwell[6]=10` -> strobe fires the following cycle; `en=0` during FIRE -> strobe still completes, then IDLE with `cnt=0`.
- With the macro defined: run 3 full laps -> `lap=3`; assert `lap_clr` in the same cycle as `t[7]` -> `lap=0`; assert `rst` mid-lap -> `lap=0`, `t=0`, `dwell` all-ones.
